rc_stream: RTL and testbench
============================

RC_STREAM -- requirements
Module: rc_stream

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits.
REQ-002 Parameter CNT_W, default 8: width of the packet word counter.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 mode  input  1  0 = per-word, 1 = packet reduction; sampled only when idle.
REQ-007 in_valid  input  1  the input word is present.
REQ-008 in_ready  output  1  the block accepts the word this cycle.
REQ-009 in_a  input  WIDTH  operand A.
REQ-010 in_b  input  WIDTH  operand B.
REQ-011 in_last  input  1  the word is the last of its packet; mode 1 only.
REQ-012 out_valid  output  1  a result is present.
REQ-013 out_ready  input  1  the consumer takes the result this cycle.
REQ-014 out_z  output  WIDTH  AND result.
REQ-015 out_w  output  WIDTH  OR result.
REQ-016 out_count  output  CNT_W  number of words in the result.
REQ-017 out_sat  output  1  out_count saturated.

Function
REQ-018 Transfers: an input transfer occurs only when in_valid and in_ready are both 1; an output transfer occurs only when out_valid and out_ready are both 1.
REQ-019 States: IDLE, ACCUM, HOLD.
REQ-020 Mode latch: mode is latched on the first accepted word in IDLE; mode changes in ACCUM or HOLD are ignored.
REQ-021 Mode 0 result: each accepted word produces out_z=a&b, out_w=a|b, out_count=1 and out_sat=0, registered with a latency of 1 cycle.
REQ-022 Mode 0 handshake: in_ready = !out_valid || out_ready, giving full throughput with no bubbles; in_last is ignored.
REQ-023 Mode 1, first word: the first accepted word loads z_acc=a&b, w_acc=a|b and count=1, and the block moves IDLE->ACCUM.
REQ-024 Mode 1, subsequent words: each later accepted word updates z_acc&=(a&b), w_acc|=(a|b) and count+=1.
REQ-025 Count saturation: count saturates at 2^CNT_W-1 with no wrap; the sticky flag sat is set when saturated.
REQ-026 Mode 1 completion: an accepted word with in_last=1 is folded into the accumulators, then the block goes to HOLD with out_valid=1 on the next cycle.
REQ-027 Single-word packet: a first word with in_last=1 goes directly to HOLD with count=1.
REQ-028 HOLD: in_ready=0 and outputs are held stable while out_ready=0; an output transfer returns the block to IDLE and clears out_valid.
REQ-029 in_ready: in_ready=1 in IDLE and ACCUM, except as stated in REQ-022.
REQ-030 Unhandshaked inputs: in_valid without in_ready has no effect on any state.

Reset
REQ-031 rst_n=0 SHALL force immediately, including mid-packet or in HOLD: state=IDLE, accumulators=0, count=0, sat=0, out_valid=0, out_z=0, out_w=0, out_count=0, out_sat=0, in_ready=0.
REQ-032 in_ready SHALL rise on the first clock edge after rst_n deasserts.
REQ-033 A partial packet interrupted by reset is discarded; the next packet starts with count=1.

Structure
REQ-034 Shared package rc_pkg SHALL hold the state enumeration (IDLE/ACCUM/HOLD) and the mode constants MODE_WORD=0 and MODE_PKT=1.
REQ-035 Sub-module rc_bitwise SHALL be parametrised by WIDTH, be purely combinational, and compute z=a&b, w=a|b; it is instantiated once.
REQ-036 The FSM, accumulators, counter and output register SHALL reside in rc_stream.

Verification (WIDTH=8, CNT_W=8 unless noted)
REQ-037 Mode 0: a=F0, b=3C with out_ready=1 -> next cycle out_valid=1, out_z=30, out_w=FC, out_count=1, out_sat=0.
REQ-038 Mode 1, three words: (0E,0F), (3C,0C), (48,0A,last) -> out_z=08, out_w=7F, out_count=3, out_sat=0.
REQ-039 Backpressure in HOLD: out_ready=0 for 5 cycles while in_valid=1 -> out_valid, out_z, out_w and out_count stable, in_ready=0, no word consumed; out_ready=1 -> IDLE next cycle.
REQ-040 Saturation (CNT_W=2): 6-word mode-1 packet -> out_count=3, out_sat=1.
REQ-041 Reset and mode change: mode toggled mid-packet -> ignored, packet finishes as reduction; rst_n pulsed after 2 words -> all outputs 0 at once; next 1-word packet (FF,AA,last) -> out_z=AA, out_w=FF, out_count=1.
REQ-042 Full truth table: all four 1-bit (a,b) combinations per bit lane in mode 0 -> z=a&b and w=a|b in every lane.

Source files
------------

// File: rtl/rc_pkg.sv
// rc_pkg: types and constants shared across the rc_stream codebase.
//   rc_state_e : control FSM states (IDLE / ACCUM / HOLD)
//   MODE_WORD  : per-word result mode
//   MODE_PKT   : packet reduction mode
package rc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } rc_state_e;

    localparam logic MODE_WORD = 1'b0;
    localparam logic MODE_PKT  = 1'b1;

endpackage : rc_pkg

// File: rtl/rc_bitwise.sv
// rc_bitwise: purely combinational lane-wise AND / OR of two operands.
//   a, b : operands (WIDTH bits)
//   z    : a & b
//   w    : a | b
module rc_bitwise #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] z,
    output logic [WIDTH-1:0] w
);

    assign z = a & b;
    assign w = a | b;

endmodule : rc_bitwise

// File: rtl/rc_stream.sv
// rc_stream: streaming AND/OR reducer with valid/ready handshakes.
//   mode 0 : every accepted word yields one registered result (a&b, a|b, count 1).
//   mode 1 : words are folded until in_last; the reduced result is then held
//            until the consumer takes it.
//
// Ports
//   clk, rst_n             : clock, asynchronous active-low reset
//   mode                   : 0 per-word, 1 packet reduction (sampled in IDLE)
//   in_valid/in_ready      : input handshake
//   in_a, in_b, in_last    : operands and end-of-packet marker
//   out_valid/out_ready    : output handshake
//   out_z, out_w           : AND / OR result
//   out_count, out_sat     : words in the result, count-saturated flag
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | between packets; mode-0 words stream through here
// ACCUM | mode-1 packet in progress, accumulating words
// HOLD  | mode-1 result presented, waiting for the consumer
module rc_stream
    import rc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_z,
    output logic [WIDTH-1:0] out_w,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    rc_state_e        state;
    rc_state_e        state_nxt;

    // Held low through reset and for the first edge after it, so in_ready
    // only rises on the first clock edge after rst_n deasserts.
    logic             rdy_en;
    logic             mode_q;

    logic [WIDTH-1:0] z_acc;
    logic [WIDTH-1:0] w_acc;
    logic [CNT_W-1:0] count;
    logic             sat;

    logic [WIDTH-1:0] bw_z;
    logic [WIDTH-1:0] bw_w;

    logic             rdy;
    logic             out_fire;
    logic             ld_word;
    logic             ld_first;
    logic             ld_next;

    logic [WIDTH-1:0] z_nxt;
    logic [WIDTH-1:0] w_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             sat_nxt;

    rc_bitwise #(.WIDTH(WIDTH)) u_bitwise (
        .a (in_a),
        .b (in_b),
        .z (bw_z),
        .w (bw_w)
    );

    assign in_ready = rdy;
    assign out_fire = out_valid && out_ready;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rdy       = 1'b0;
        ld_word   = 1'b0;
        ld_first  = 1'b0;
        ld_next   = 1'b0;
        case (state)
            IDLE: begin
                // A pending mode-0 result blocks input unless it drains now.
                rdy = rdy_en && (!out_valid || out_ready);
                if (in_valid && rdy) begin
                    if (mode == MODE_WORD) begin
                        ld_word = 1'b1;
                    end else begin
                        ld_first  = 1'b1;
                        state_nxt = in_last ? HOLD : ACCUM;
                    end
                end
            end
            ACCUM: begin
                rdy = rdy_en;
                if (in_valid && rdy && (mode_q == MODE_PKT)) begin
                    ld_next = 1'b1;
                    if (in_last) begin
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_fire) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------- accumulators
    always_comb begin
        z_nxt   = ld_first ? bw_z : (z_acc & bw_z);
        w_nxt   = ld_first ? bw_w : (w_acc | bw_w);
        cnt_nxt = CNT_ONE;
        if (!ld_first) begin
            cnt_nxt = (count == CNT_MAX) ? count : (count + CNT_ONE);
        end
        // Sticky within a packet; a new packet starts clean.
        sat_nxt = (cnt_nxt == CNT_MAX) || (sat && !ld_first);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en <= 1'b0;
            mode_q <= MODE_WORD;
            z_acc  <= '0;
            w_acc  <= '0;
            count  <= '0;
            sat    <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (state == IDLE && in_valid && rdy) begin
                mode_q <= mode;
            end
            if (ld_first || ld_next) begin
                z_acc <= z_nxt;
                w_acc <= w_nxt;
                count <= cnt_nxt;
                sat   <= sat_nxt;
            end
        end
    end

    // ---------------------------------------------------- output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_z     <= '0;
            out_w     <= '0;
            out_count <= '0;
            out_sat   <= 1'b0;
        end else if (ld_word) begin
            out_valid <= 1'b1;
            out_z     <= bw_z;
            out_w     <= bw_w;
            out_count <= CNT_ONE;
            out_sat   <= 1'b0;
        end else if ((ld_first || ld_next) && in_last) begin
            // The closing word is folded straight into the result register.
            out_valid <= 1'b1;
            out_z     <= z_nxt;
            out_w     <= w_nxt;
            out_count <= cnt_nxt;
            out_sat   <= sat_nxt;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

endmodule : rc_stream

// File: tb/tb_rc_stream.sv
// tb_rc_stream: directed + randomized bench for rc_stream. Two instances share
// all inputs and differ only in CNT_W (8 and 2) so saturation is exercised
// alongside normal counting.
module tb_rc_stream;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] in_a = 8'h00;
    logic [7:0] in_b = 8'h00;

    logic       rdy8, rdy2, ov8, ov2, s8, s2;
    logic [7:0] z8, w8, z2, w2, c8;
    logic [1:0] c2;

    int tests = 0;
    int fails = 0;

    logic [7:0] da[$];
    logic [7:0] db[$];

    always #5 clk = ~clk;

    rc_stream #(.WIDTH(8), .CNT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(rdy8),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(ov8), .out_ready(out_ready),
        .out_z(z8), .out_w(w8), .out_count(c8), .out_sat(s8)
    );

    rc_stream #(.WIDTH(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(rdy2),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(ov2), .out_ready(out_ready),
        .out_z(z2), .out_w(w2), .out_count(c2), .out_sat(s2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ready(input string tag, input logic exp);
        chk({tag, ".rdy8"}, 32'(rdy8), 32'(exp));
        chk({tag, ".rdy2"}, 32'(rdy2), 32'(exp));
    endtask

    // Expected result of n folded words: count clips at 2^CNT_W-1 and the
    // flag reports that the count sits at that ceiling.
    task automatic chk_result(input string tag, input logic [7:0] ez, input logic [7:0] ew, input int n);
        int e8;
        int e2;
        e8 = (n > 255) ? 255 : n;
        e2 = (n > 3) ? 3 : n;
        chk({tag, ".valid8"}, 32'(ov8), 32'd1);
        chk({tag, ".z8"},     32'(z8),  32'(ez));
        chk({tag, ".w8"},     32'(w8),  32'(ew));
        chk({tag, ".cnt8"},   32'(c8),  32'(e8));
        chk({tag, ".sat8"},   32'(s8),  32'(e8 == 255));
        chk({tag, ".valid2"}, 32'(ov2), 32'd1);
        chk({tag, ".z2"},     32'(z2),  32'(ez));
        chk({tag, ".w2"},     32'(w2),  32'(ew));
        chk({tag, ".cnt2"},   32'(c2),  32'(e2));
        chk({tag, ".sat2"},   32'(s2),  32'(e2 == 3));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".valid8"}, 32'(ov8), 32'd0);
        chk({tag, ".z8"},     32'(z8),  32'd0);
        chk({tag, ".w8"},     32'(w8),  32'd0);
        chk({tag, ".cnt8"},   32'(c8),  32'd0);
        chk({tag, ".sat8"},   32'(s8),  32'd0);
        chk({tag, ".valid2"}, 32'(ov2), 32'd0);
        chk({tag, ".cnt2"},   32'(c2),  32'd0);
        chk({tag, ".sat2"},   32'(s2),  32'd0);
        chk_ready(tag, 1'b0);
    endtask

    // One mode-0 word, consumer ready; result expected one cycle later.
    task automatic word0(input string tag, input logic [7:0] a, input logic [7:0] b);
        mode = 1'b0; in_valid = 1'b1; in_a = a; in_b = b; in_last = $urandom_range(0, 1);
        out_ready = 1'b1;
        #1 chk_ready(tag, 1'b1);
        @(negedge clk);
        chk_result(tag, a & b, a | b, 1);
    endtask

    task automatic drain(input string tag);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk({tag, ".drained8"}, 32'(ov8), 32'd0);
        chk({tag, ".drained2"}, 32'(ov2), 32'd0);
        out_ready = 1'b0;
        #1 chk_ready({tag, ".idle"}, 1'b1);
    endtask

    // Mode-1 packet of n words (directed from da/db when loaded, else random).
    // toggle drives mode=0 on every word after the first. hold is the number of
    // backpressured cycles in HOLD with junk words offered.
    task automatic send_pkt(input string tag, input int n, input bit toggle,
                            input int hold, input bit do_drain);
        logic [7:0] a, b, ez, ew;
        ez = 8'hFF;
        ew = 8'h00;
        for (int i = 0; i < n; i++) begin
            if (i > 0 && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_a = $urandom; in_b = $urandom;
                @(negedge clk);
            end
            if (da.size() > 0) begin
                a = da.pop_front();
                b = db.pop_front();
            end else begin
                a = $urandom;
                b = $urandom;
            end
            ez = ez & (a & b);
            ew = ew | (a | b);
            mode = (i == 0) ? 1'b1 : (toggle ? 1'b0 : 1'b1);
            in_valid = 1'b1; in_a = a; in_b = b; in_last = (i == n - 1); out_ready = 1'b0;
            #1 chk_ready({tag, ".accept"}, 1'b1);
            @(negedge clk);
        end
        in_valid = 1'b0; in_last = 1'b0;
        chk_result(tag, ez, ew, n);
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1; in_a = $urandom; in_b = $urandom;
            in_last = $urandom_range(0, 1); mode = $urandom_range(0, 1);
            #1 chk_ready({tag, ".hold"}, 1'b0);
            @(negedge clk);
            chk_result({tag, ".held"}, ez, ew, n);
        end
        in_valid = 1'b0;
        if (do_drain) drain(tag);
    endtask

    initial begin
        logic [7:0] pa, pb, qa, qb;

        // Power-on reset.
        #1 chk_zero("por");
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk_ready("por.release", 1'b0);
        @(negedge clk);
        chk_ready("por.first_edge", 1'b1);

        // Mode 0 directed and full truth table across lanes.
        word0("m0.f0_3c", 8'hF0, 8'h3C);
        chk("m0.f0_3c.z", 32'(z8), 32'h30);
        chk("m0.f0_3c.w", 32'(w8), 32'hFC);
        word0("m0.truth", 8'hCC, 8'hAA);
        chk("m0.truth.z", 32'(z8), 32'h88);
        chk("m0.truth.w", 32'(w8), 32'hEE);

        // Mode 0 back-to-back streaming, one result per cycle.
        for (int i = 0; i < 20; i++) begin
            pa = $urandom; pb = $urandom;
            word0("m0.stream", pa, pb);
        end

        // Mode 0 backpressure: pending result blocks the next word.
        qa = $urandom; qb = $urandom;
        in_valid = 1'b1; in_a = qa; in_b = qb; out_ready = 1'b0;
        #1 chk_ready("m0.bp", 1'b0);
        @(negedge clk);
        chk_result("m0.bp.held", pa & pb, pa | pb, 1);
        out_ready = 1'b1;
        #1 chk_ready("m0.bp.release", 1'b1);
        @(negedge clk);
        chk_result("m0.bp.next", qa & qb, qa | qb, 1);
        drain("m0.bp");

        // Mode 1 three-word packet with 5 cycles of HOLD backpressure.
        da = '{8'h0E, 8'h3C, 8'h48};
        db = '{8'h0F, 8'h0C, 8'h0A};
        send_pkt("m1.three", 3, 1'b0, 5, 1'b0);
        chk("m1.three.z", 32'(z8), 32'h08);
        chk("m1.three.w", 32'(w8), 32'h7F);
        chk("m1.three.cnt", 32'(c8), 32'd3);
        drain("m1.three");

        // Saturation: 6 words clip the 2-bit counter at 3.
        send_pkt("m1.sat6", 6, 1'b0, 1, 1'b1);

        // Mode change mid-packet is ignored.
        send_pkt("m1.toggle", 4, 1'b1, 0, 1'b1);

        // Randomized packets.
        for (int p = 0; p < 12; p++) begin
            send_pkt("m1.rand", $urandom_range(1, 9), $urandom_range(0, 1),
                     $urandom_range(0, 3), 1'b1);
        end

        // Reset while holding a result.
        send_pkt("rst.hold", 2, 1'b0, 1, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk_zero("rst.hold");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset after 2 words of a packet (mode toggled on word 2).
        for (int i = 0; i < 2; i++) begin
            mode = (i == 0) ? 1'b1 : 1'b0;
            in_valid = 1'b1; in_a = $urandom; in_b = $urandom; in_last = 1'b0;
            #1 chk_ready("rst.mid.accept", 1'b1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_zero("rst.mid");
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk_ready("rst.mid.release", 1'b0);
        @(negedge clk);
        chk_ready("rst.mid.first_edge", 1'b1);

        // Partial packet discarded: single-word packet restarts at count 1.
        da = '{8'hFF};
        db = '{8'hAA};
        send_pkt("rst.next", 1, 1'b0, 0, 1'b0);
        chk("rst.next.z", 32'(z8), 32'hAA);
        chk("rst.next.w", 32'(w8), 32'hFF);
        chk("rst.next.cnt", 32'(c8), 32'd1);
        drain("rst.next");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_rc_stream
